// File: rtl/bank_isu_linefill_req_ctrl.sv
// Linefill read-request controller for one cache bank.
// Queues HTU linefill requests in a small FIFO and issues them as single-beat
// AR transactions tagged {set,way}. It caps the number of reads in flight and
// retires one outstanding read per BIU R beat.
module bank_isu_linefill_req_ctrl #(
  parameter int DEPTH           = 4,
  parameter int MAX_OUTSTANDING = 8,
  parameter int ADDR_WIDTH      = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  lf_req_valid_i,
  output logic                  lf_req_ready_o,
  input  logic [2:0]            lf_req_set_i,
  input  logic [2:0]            lf_req_way_i,
  input  logic [ADDR_WIDTH-1:0] lf_req_addr_i,
  output logic                  isu_biu_arvalid_o,
  input  logic                  biu_isu_arready_i,
  output logic [ADDR_WIDTH-1:0] isu_biu_araddr_o,
  output logic [5:0]            isu_biu_arid_o,
  input  logic                  biu_isu_rvalid_i,
  output logic [6:0]            lf_outstanding_cnt_o,
  output logic                  lf_idle_o,
  output logic                  lf_err_o
);

  localparam int          PW      = $clog2(DEPTH);
  localparam logic [PW:0] PTR_ONE = (PW+1)'(1);
  localparam logic [6:0]  MAX_CNT = 7'(MAX_OUTSTANDING);

  // Pointers carry one wrap bit above the index so full and empty are distinct.
  logic [PW:0]           wr_ptr_q, wr_ptr_d;
  logic [PW:0]           rd_ptr_q, rd_ptr_d;
  logic [6:0]            cnt_q, cnt_d;
  logic                  err_q, err_d;

  // Entry storage is data only; it carries no reset.
  logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
  logic [5:0]            id_mem   [DEPTH];

  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;
  logic                  cnt_ok;
  logic                  arvalid;

  assign full    = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                   (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign cnt_ok  = (cnt_q < MAX_CNT);

  // arvalid cannot drop while it waits: cnt only rises on a handshake, and the
  // head only moves on a pop. AXI stability therefore needs no extra holding state.
  assign arvalid = ~empty & cnt_ok;
  assign push    = lf_req_valid_i & ~full;
  assign pop     = arvalid & biu_isu_arready_i;

  assign lf_req_ready_o       = ~full;
  assign isu_biu_arvalid_o    = arvalid;
  assign isu_biu_araddr_o     = empty ? '0 : addr_mem[rd_ptr_q[PW-1:0]];
  assign isu_biu_arid_o       = empty ? '0 : id_mem[rd_ptr_q[PW-1:0]];
  assign lf_outstanding_cnt_o = cnt_q;
  assign lf_idle_o            = empty & (cnt_q == 7'd0);
  assign lf_err_o             = err_q;

  // Next-state: pointer advance, in-flight count and sticky underflow error.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    unique case ({pop, biu_isu_rvalid_i})
      2'b10: cnt_d = cnt_q + 7'd1;
      2'b01: begin
        // An R beat with nothing in flight is a stray: hold the count at
        // zero and flag it until the next reset.
        if (cnt_q == 7'd0) begin
          err_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 7'd1;
        end
      end
      default: cnt_d = cnt_q;
    endcase
  end

  // Control state register; async reset forgets all queued and in-flight reads.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  // Entry write on push; the head is read combinationally for the AR payload.
  always_ff @(posedge clk_i) begin
    if (push) begin
      addr_mem[wr_ptr_q[PW-1:0]] <= lf_req_addr_i;
      id_mem[wr_ptr_q[PW-1:0]]   <= {lf_req_set_i, lf_req_way_i};
    end
  end

endmodule

// File: tb/tb_bank_isu_linefill_req_ctrl.sv
// Testbench for bank_isu_linefill_req_ctrl: directed scenarios plus a
// cycle-by-cycle reference model and an AR scoreboard.
module tb_bank_isu_linefill_req_ctrl;

  localparam int DEPTH = 4;
  localparam int MAXO  = 8;
  localparam int AW    = 32;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          lf_req_valid_i;
  logic          lf_req_ready_o;
  logic [2:0]    lf_req_set_i;
  logic [2:0]    lf_req_way_i;
  logic [AW-1:0] lf_req_addr_i;
  logic          isu_biu_arvalid_o;
  logic          biu_isu_arready_i;
  logic [AW-1:0] isu_biu_araddr_o;
  logic [5:0]    isu_biu_arid_o;
  logic          biu_isu_rvalid_i;
  logic [6:0]    lf_outstanding_cnt_o;
  logic          lf_idle_o;
  logic          lf_err_o;

  bank_isu_linefill_req_ctrl #(
    .DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .ADDR_WIDTH(AW)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .lf_req_valid_i(lf_req_valid_i),
    .lf_req_ready_o(lf_req_ready_o),
    .lf_req_set_i(lf_req_set_i),
    .lf_req_way_i(lf_req_way_i),
    .lf_req_addr_i(lf_req_addr_i),
    .isu_biu_arvalid_o(isu_biu_arvalid_o),
    .biu_isu_arready_i(biu_isu_arready_i),
    .isu_biu_araddr_o(isu_biu_araddr_o),
    .isu_biu_arid_o(isu_biu_arid_o),
    .biu_isu_rvalid_i(biu_isu_rvalid_i),
    .lf_outstanding_cnt_o(lf_outstanding_cnt_o),
    .lf_idle_o(lf_idle_o),
    .lf_err_o(lf_err_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [5:0]    id;
  } ar_t;

  ar_t sb_q[$];
  int  n_chk  = 0;
  int  n_pass = 0;
  int  m_cnt  = 0;
  bit  m_err  = 1'b0;
  bit  m_av, m_rdy, m_hs;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Reference model, sampled on the falling edge: compare the outputs, then
  // advance the model by what the coming rising edge will see.
  always @(negedge clk) begin
    if (rst_i) begin
      sb_q.delete();
      m_cnt = 0;
      m_err = 1'b0;
    end else begin
      m_av  = (sb_q.size() != 0) && (m_cnt < MAXO);
      m_rdy = (sb_q.size() < DEPTH);
      chk("ready",   lf_req_ready_o, m_rdy);
      chk("arvalid", isu_biu_arvalid_o, m_av);
      chk("cnt",     lf_outstanding_cnt_o, m_cnt);
      chk("idle",    lf_idle_o, (sb_q.size() == 0) && (m_cnt == 0));
      chk("err",     lf_err_o, m_err);
      if (sb_q.size() != 0) begin
        chk("araddr", isu_biu_araddr_o, sb_q[0].addr);
        chk("arid",   isu_biu_arid_o, sb_q[0].id);
      end else begin
        chk("araddr_empty", isu_biu_araddr_o, 0);
        chk("arid_empty",   isu_biu_arid_o, 0);
      end
      m_hs = m_av && biu_isu_arready_i;
      if (m_hs) void'(sb_q.pop_front());
      if (m_hs && !biu_isu_rvalid_i) m_cnt++;
      else if (!m_hs && biu_isu_rvalid_i) begin
        if (m_cnt == 0) m_err = 1'b1;
        else m_cnt--;
      end
      if (lf_req_valid_i && m_rdy)
        sb_q.push_back('{addr: lf_req_addr_i, id: {lf_req_set_i, lf_req_way_i}});
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_req(input logic [AW-1:0] a, input logic [2:0] s, input logic [2:0] w);
    bit acc = 1'b0;
    lf_req_valid_i = 1'b1;
    lf_req_addr_i  = a;
    lf_req_set_i   = s;
    lf_req_way_i   = w;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (lf_req_ready_o) begin
        acc = 1'b1;
        break;
      end
    end
    chk("push_accept", acc, 1);
    cyc();
    lf_req_valid_i = 1'b0;
  endtask

  task automatic drain();
    biu_isu_arready_i = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (lf_idle_o) break;
      biu_isu_rvalid_i = (lf_outstanding_cnt_o != 7'd0);
      cyc();
    end
    biu_isu_rvalid_i = 1'b0;
    chk("drain_idle", lf_idle_o, 1);
  endtask

  initial begin
    bit acc;
    rst_i             = 1'b1;
    lf_req_valid_i    = 1'b0;
    lf_req_set_i      = '0;
    lf_req_way_i      = '0;
    lf_req_addr_i     = '0;
    biu_isu_arready_i = 1'b0;
    biu_isu_rvalid_i  = 1'b0;
    repeat (3) cyc();
    rst_i = 1'b0;
    cyc();

    // Reset values
    chk("rst_ready",   lf_req_ready_o, 1);
    chk("rst_arvalid", isu_biu_arvalid_o, 0);
    chk("rst_cnt",     lf_outstanding_cnt_o, 0);
    chk("rst_idle",    lf_idle_o, 1);
    chk("rst_err",     lf_err_o, 0);

    // Single request: issue the cycle after acceptance
    biu_isu_arready_i = 1'b1;
    push_req(32'h1000, 3'd5, 3'd2);
    chk("single_arvalid", isu_biu_arvalid_o, 1);
    chk("single_arid",    isu_biu_arid_o, 6'b101_010);
    chk("single_araddr",  isu_biu_araddr_o, 32'h1000);
    cyc();
    chk("single_cnt1", lf_outstanding_cnt_o, 1);
    biu_isu_rvalid_i = 1'b1;
    cyc();
    biu_isu_rvalid_i = 1'b0;
    chk("single_cnt0", lf_outstanding_cnt_o, 0);
    chk("single_idle", lf_idle_o, 1);

    // Backpressure: fill, hold stable, then burst out in order
    biu_isu_arready_i = 1'b0;
    for (int i = 0; i < 4; i++)
      push_req(32'hA000 + 32'(i) * 32'h40, 3'(i + 1), 3'(7 - i));
    chk("bp_ready_low", lf_req_ready_o, 0);
    lf_req_valid_i = 1'b1;
    lf_req_addr_i  = 32'hA100;
    lf_req_set_i   = 3'd6;
    lf_req_way_i   = 3'd6;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("bp_hold_valid", isu_biu_arvalid_o, 1);
      chk("bp_hold_addr",  isu_biu_araddr_o, 32'hA000);
      chk("bp_hold_id",    isu_biu_arid_o, 6'b001_111);
    end
    biu_isu_arready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i < 4) chk("bp_b2b", isu_biu_arvalid_o && biu_isu_arready_i, 1);
      acc = lf_req_valid_i && lf_req_ready_o;
      cyc();
      if (acc) lf_req_valid_i = 1'b0;
    end
    chk("bp_fifth_taken", lf_req_valid_i, 0);
    drain();

    // Outstanding limit
    for (int i = 0; i < 10; i++)
      push_req(32'h4000 + 32'(i) * 32'h40, 3'(i), 3'(~i));
    cyc();
    cyc();
    chk("lim_cnt8",    lf_outstanding_cnt_o, MAXO);
    chk("lim_arvalid", isu_biu_arvalid_o, 0);
    biu_isu_rvalid_i = 1'b1;
    cyc();
    biu_isu_rvalid_i = 1'b0;
    chk("lim_cnt7",     lf_outstanding_cnt_o, MAXO - 1);
    chk("lim_reassert", isu_biu_arvalid_o, 1);
    drain();

    // Simultaneous handshake and R beat at cnt=3
    biu_isu_arready_i = 1'b0;
    for (int i = 0; i < 4; i++)
      push_req(32'h8000 + 32'(i) * 32'h40, 3'(i), 3'(i));
    biu_isu_arready_i = 1'b1;
    repeat (3) cyc();
    chk("sim_cnt3_pre", lf_outstanding_cnt_o, 3);
    chk("sim_arvalid",  isu_biu_arvalid_o, 1);
    biu_isu_rvalid_i = 1'b1;
    cyc();
    biu_isu_rvalid_i = 1'b0;
    chk("sim_cnt3_post", lf_outstanding_cnt_o, 3);
    drain();

    // Underflow: sticky error
    biu_isu_rvalid_i = 1'b1;
    cyc();
    biu_isu_rvalid_i = 1'b0;
    chk("uf_err", lf_err_o, 1);
    chk("uf_cnt", lf_outstanding_cnt_o, 0);
    push_req(32'hC000, 3'd3, 3'd4);
    drain();
    chk("uf_err_sticky", lf_err_o, 1);
    rst_i = 1'b1;
    #1;
    chk("uf_err_cleared", lf_err_o, 0);
    chk("uf_idle_rst",    lf_idle_o, 1);
    cyc();
    rst_i = 1'b0;
    cyc();

    // Mid-burst async reset; the forgotten read's R beat is a stray
    biu_isu_arready_i = 1'b1;
    push_req(32'hD000, 3'd1, 3'd1);
    cyc();
    biu_isu_arready_i = 1'b0;
    push_req(32'hD040, 3'd2, 3'd2);
    push_req(32'hD080, 3'd3, 3'd3);
    chk("mid_arvalid_pre", isu_biu_arvalid_o, 1);
    chk("mid_cnt_pre",     lf_outstanding_cnt_o, 1);
    rst_i = 1'b1;
    #1;
    chk("mid_arvalid_rst", isu_biu_arvalid_o, 0);
    chk("mid_cnt_rst",     lf_outstanding_cnt_o, 0);
    chk("mid_araddr_rst",  isu_biu_araddr_o, 0);
    cyc();
    rst_i = 1'b0;
    cyc();
    biu_isu_rvalid_i = 1'b1;
    cyc();
    biu_isu_rvalid_i = 1'b0;
    chk("mid_stray_err", lf_err_o, 1);
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
